// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin arbiter for valid/ready streams: zero-latency pass-through,
// each input may send up to its weight in consecutive beats before the turn moves on.
module stream_wrr_arbiter #(
    parameter int unsigned NumInp      = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4,
    parameter bit          LockIn      = 1'b1,
    localparam int unsigned IdxW       = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NumInp*WeightWidth-1:0] weights_i,
    input  logic [NumInp*DataWidth-1:0]   inp_data_i,
    input  logic [NumInp-1:0]             inp_valid_i,
    output logic [NumInp-1:0]             inp_ready_o,
    output logic [DataWidth-1:0]          oup_data_o,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i,
    output logic [IdxW-1:0]               oup_idx_o
);

    typedef logic [IdxW-1:0] idx_t;

    idx_t                   ptr_q;
    logic [WeightWidth-1:0] used_q;
    logic                   lock_q;
    idx_t                   lock_idx_q;

    idx_t                   sel;
    logic                   found;
    logic [IdxW:0]          cand;
    logic [WeightWidth-1:0] weight_raw;
    logic [WeightWidth:0]   weight_eff;
    logic [WeightWidth:0]   used_next;
    logic                   hs;
    logic                   turn_done;

    // Rotating priority scan starting at ptr_q; a locked grant overrides the scan.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        cand  = '0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NumInp; k++) begin
                cand = {1'b0, ptr_q} + (IdxW+1)'(k);
                if (cand >= (IdxW+1)'(NumInp)) begin
                    cand = cand - (IdxW+1)'(NumInp);
                end
                if (!found && inp_valid_i[cand[IdxW-1:0]]) begin
                    sel   = cand[IdxW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        oup_valid_o = inp_valid_i[sel];
        oup_data_o  = inp_data_i[int'(sel)*DataWidth +: DataWidth];
        oup_idx_o   = sel;
        // Ready only follows oup_ready_i through the selection, never the selected valid.
        inp_ready_o = '0;
        if (|inp_valid_i) begin
            inp_ready_o[sel] = oup_ready_i;
        end
    end

    assign hs = oup_valid_o & oup_ready_i;

    // A zero weight still grants one beat per turn.
    always_comb begin
        weight_raw = weights_i[int'(sel)*WeightWidth +: WeightWidth];
        weight_eff = (weight_raw == '0) ? (WeightWidth+1)'(1) : {1'b0, weight_raw};
        used_next  = ((sel == ptr_q) ? {1'b0, used_q} : '0) + (WeightWidth+1)'(1);
        turn_done  = (used_next >= weight_eff);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            ptr_q      <= '0;
            used_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (hs) begin
            lock_q <= 1'b0;
            if (turn_done) begin
                ptr_q  <= (sel == idx_t'(NumInp - 1)) ? '0 : sel + idx_t'(1);
                used_q <= '0;
            end else begin
                ptr_q  <= sel;
                used_q <= used_next[WeightWidth-1:0];
            end
        end else if (LockIn && oup_valid_o && !oup_ready_i) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Directed-vector bench for stream_wrr_arbiter; expected beats go into a scoreboard
// queue and a negedge monitor compares them whenever the arbiter presents valid data.
module tb_stream_wrr_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic [15:0]  weights_i;
    logic [127:0] inp_data_i;
    logic [3:0]   inp_valid_i;
    logic [3:0]   inp_ready_o;
    logic [31:0]  oup_data_o;
    logic         oup_valid_o;
    logic         oup_ready_i;
    logic [1:0]   oup_idx_o;

    stream_wrr_arbiter #(
        .NumInp     (4),
        .DataWidth  (32),
        .WeightWidth(4),
        .LockIn     (1'b1)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .weights_i  (weights_i),
        .inp_data_i (inp_data_i),
        .inp_valid_i(inp_valid_i),
        .inp_ready_o(inp_ready_o),
        .oup_data_o (oup_data_o),
        .oup_valid_o(oup_valid_o),
        .oup_ready_i(oup_ready_i),
        .oup_idx_o  (oup_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
        logic [3:0]  rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   beat_no  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (beat %0d): got %0h, expected %0h", name, beat_no, act, exp);
    endtask

    function automatic logic [31:0] data_of(input int i);
        return 32'hCAFE_0000 | (32'(i + 1) * 32'h111);
    endfunction

    // Drive one cycle of stimulus; exp_idx < 0 means no beat is expected this cycle.
    task automatic step(input logic [3:0] v, input logic rdy, input int exp_idx,
                        input logic rst, input logic fl);
        exp_t e;
        @(posedge clk_i);
        #1;
        inp_valid_i = v;
        oup_ready_i = rdy;
        rst_ni      = rst;
        flush_i     = fl;
        if (exp_idx >= 0) begin
            e.idx  = 2'(exp_idx);
            e.data = data_of(exp_idx);
            e.rdy  = rdy ? 4'(1 << exp_idx) : 4'b0000;
            sb_q.push_back(e);
        end
    endtask

    task automatic beat(input logic [3:0] v, input int exp_idx);
        step(v, 1'b1, exp_idx, 1'b1, 1'b0);
    endtask

    task automatic stall(input logic [3:0] v, input int exp_idx);
        step(v, 1'b0, exp_idx, 1'b1, 1'b0);
    endtask

    // Weights change only while reset is applied, so no pending handshake sees them.
    task automatic do_reset(input logic [15:0] w);
        step(4'b0000, 1'b1, -1, 1'b0, 1'b0);
        weights_i = w;
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (oup_valid_o) begin
            beat_no++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat (beat %0d): got idx %0d, expected no valid output",
                         beat_no, oup_idx_o);
            end else begin
                e = sb_q.pop_front();
                check("oup_idx", 64'(oup_idx_o), 64'(e.idx));
                check("oup_data", 64'(oup_data_o), 64'(e.data));
                check("inp_ready", 64'(inp_ready_o), 64'(e.rdy));
            end
        end
    end

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        inp_valid_i = '0;
        oup_ready_i = 1'b1;
        weights_i   = 16'h1111;
        for (int i = 0; i < 4; i++) inp_data_i[i*32 +: 32] = data_of(i);

        // Reset state with nothing valid
        step(4'b0000, 1'b1, -1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, -1, 1'b1, 1'b0);
        @(negedge clk_i);
        check("reset_valid", 64'(oup_valid_o), 64'(0));
        check("reset_idx", 64'(oup_idx_o), 64'(0));
        check("reset_ready", 64'(inp_ready_o), 64'(0));

        // Equal weights: plain round robin
        beat(4'b1111, 0); beat(4'b1111, 1); beat(4'b1111, 2);
        beat(4'b1111, 3); beat(4'b1111, 0);

        // Weights {3,1,2,1} with an idle cycle that must hold ptr/used
        do_reset(16'h1213);
        beat(4'b1111, 0); beat(4'b1111, 0);
        step(4'b0000, 1'b1, -1, 1'b1, 1'b0);
        beat(4'b1111, 0); beat(4'b1111, 1); beat(4'b1111, 2);
        beat(4'b1111, 2); beat(4'b1111, 3); beat(4'b1111, 0);

        // Lone input 2 with weight 3; after the third beat the turn has moved to 3
        do_reset(16'h1311);
        beat(4'b0100, 2); beat(4'b0100, 2); beat(4'b0100, 2);
        beat(4'b1111, 3);
        beat(4'b0100, 2); beat(4'b0100, 2);

        // Lock: a lower-index input appearing during a stall must not steal the grant
        do_reset(16'h1111);
        stall(4'b0010, 1); stall(4'b0011, 1); stall(4'b0011, 1);
        beat(4'b0011, 1); beat(4'b0011, 0);

        // Lock with ptr at 1, inputs 1 and 3 valid, input 0 joining while stalled
        do_reset(16'h1111);
        beat(4'b0001, 0);
        stall(4'b1010, 1); stall(4'b1011, 1); stall(4'b1011, 1); stall(4'b1011, 1);
        beat(4'b1011, 1); beat(4'b1011, 3);

        // Weight 0 on input 1 behaves as weight 1
        do_reset(16'h1102);
        beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 1); beat(4'b1111, 2);
        beat(4'b1111, 3); beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 1);

        // Reset mid-stream while a grant on input 2 is locked
        do_reset(16'h1213);
        beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 1);
        beat(4'b1111, 2);
        stall(4'b1111, 2);
        step(4'b1111, 1'b1, 2, 1'b0, 1'b0);
        beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 1);

        // Flush mid-turn: the beat in the flush cycle completes but does not count
        do_reset(16'h1213);
        beat(4'b1111, 0); beat(4'b1111, 0);
        step(4'b1111, 1'b1, 0, 1'b1, 1'b1);
        beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 0); beat(4'b1111, 1);

        step(4'b0000, 1'b1, -1, 1'b1, 1'b0);
        step(4'b0000, 1'b1, -1, 1'b1, 1'b0);
        @(negedge clk_i);
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_wrr_arbiter.md
STREAM_WRR_ARBITER -- requirements
Module: stream_wrr_arbiter

Interface
REQ-001 SHALL have parameter NumInp, default 4, number of input streams (>=2).
REQ-002 SHALL have parameter DataWidth, default 32, payload width in bits.
REQ-003 SHALL have parameter WeightWidth, default 4, width of each per-input weight.
REQ-004 SHALL have parameter LockIn, default 1, 1 = hold grant while output valid is stalled.
REQ-005 SHALL have port clk_i  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-007 SHALL have port flush_i  input  1  synchronous clear of arbitration state.
REQ-008 SHALL have port weights_i  input  NumInp*WeightWidth  per-input weight, input i at bits [i*WeightWidth +: WeightWidth].
REQ-009 SHALL have port inp_data_i  input  NumInp*DataWidth  per-input payload, same packing.
REQ-010 SHALL have port inp_valid_i  input  NumInp  per-input valid.
REQ-011 SHALL have port inp_ready_o  output  NumInp  per-input ready.
REQ-012 SHALL have port oup_data_o  output  DataWidth  selected payload.
REQ-013 SHALL have port oup_valid_o  output  1  output valid.
REQ-014 SHALL have port oup_ready_i  input  1  output ready.
REQ-015 SHALL have port oup_idx_o  output  max(1,$clog2(NumInp))  index of selected input.

Function
REQ-016 SHALL hold state ptr_q (index), used_q (WeightWidth bits, beats served in current turn), lock_q (1 bit), lock_idx_q (index).
REQ-017 SHALL, when lock_q=0, select sel = first i with inp_valid_i[i]=1 scanning ptr_q, ptr_q+1, ... modulo NumInp; when lock_q=1, sel = lock_idx_q.
REQ-018 SHALL drive oup_valid_o = inp_valid_i[sel] (0 if no input valid), oup_data_o = data of sel, oup_idx_o = sel; oup_data_o/oup_idx_o when invalid are don't-care but deterministic (sel = ptr_q).
REQ-019 SHALL drive inp_ready_o[sel] = oup_ready_i and all other inp_ready_o bits 0; combinational path valid->ready forbidden (ready depends only on oup_ready_i and state/valid-based selection, no loop).
REQ-020 SHALL define handshake hs = oup_valid_o & oup_ready_i; zero-latency pass-through, no buffering.
REQ-021 SHALL use effective weight w = weights_i[sel], with weight 0 treated as 1.
REQ-022 SHALL on hs compute u = (sel==ptr_q ? used_q : 0) + 1; if u >= w then ptr_q <= (sel+1) mod NumInp, used_q <= 0; else ptr_q <= sel, used_q <= u.
REQ-023 SHALL hold ptr_q and used_q when no hs occurs, including idle cycles with all inputs invalid.
REQ-024 SHALL, when LockIn=1 and oup_valid_o=1 and oup_ready_i=0, set lock_q <= 1, lock_idx_q <= sel; SHALL clear lock_q on hs.
REQ-025 SHALL, when LockIn=0, keep lock_q=0 permanently (grant may change while stalled).
REQ-026 SHALL sample weights_i combinationally each cycle; if used_q already >= a lowered weight, next hs on ptr_q advances ptr_q.
REQ-027 SHALL wrap ptr_q from NumInp-1 to 0; for non-power-of-two NumInp ptr_q never exceeds NumInp-1.
REQ-028 SHALL give flush_i=1 the same state effect as reset, outputs still combinational from cleared state in the following cycle; an hs in the flush cycle is completed on the interface but its state update is discarded.

Reset
REQ-029 SHALL on rising clk_i with rst_ni=0 set ptr_q=0, used_q=0, lock_q=0, lock_idx_q=0; rst_ni has priority over flush_i and hs.
REQ-030 SHALL after reset, with all inp_valid_i=0, drive oup_valid_o=0, oup_idx_o=0, inp_ready_o=0.
REQ-031 SHALL recover from reset asserted mid-transfer: stalled locked grant dropped, arbitration restarts at input 0.

Verification
REQ-032 NumInp=4, weights {1,1,1,1}, all valid, oup_ready_i=1 -> oup_idx_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 weights {3,1,2,1}, all valid, ready=1 -> sequence 0,0,0,1,2,2,3,0.
REQ-034 only input 2 valid, weight 3, ready=1 for 5 cycles -> idx 2 every cycle, ptr_q returns to 3 after 3rd beat, no stall.
REQ-035 LockIn=1, inputs 1 and 3 valid, ptr_q=1, ready=0 for 4 cycles while input 0 asserts valid -> oup_idx_o stays 1, data stable, inp_ready_o=0000; ready=1 -> hs on input 1.
REQ-036 weight 0 on input 1, all valid -> input 1 served exactly one beat per round.
REQ-037 mid-stream rst_ni=0 one cycle (and separately flush_i=1) -> next cycle oup_idx_o=0 with all valid, used_q=0.
